// File: rtl/debounce_scheduler_pkg.sv
// debounce_scheduler_pkg: shared FSM encoding and timing constants for the debounce scheduler
package debounce_scheduler_pkg;
    typedef enum logic {IDLE, COUNT} state_t;
    localparam int DEBOUNCE_LIMIT_25MHZ = 250000;
endpackage

// File: rtl/debounce_scheduler_sync_2ff.sv
// sync_2ff: parameterized-width two-flop synchronizer for asynchronous pins
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    // two-stage resynchronization into the i_Clk domain
    always_ff @(posedge i_Clk)
        if (i_Reset) {q, meta} <= '0;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: one round-robin-shared debounce counter serving NUM_SW switches
module debounce_scheduler
    import debounce_scheduler_pkg::*;
#(
    parameter int NUM_SW         = 4,
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_25MHZ
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NUM_SW-1:0] i_Switch,
    output logic [NUM_SW-1:0] o_Switch,
    output logic [NUM_SW-1:0] o_Release,
    output logic [NUM_SW-1:0] o_LED
);
    localparam int IW = $clog2(NUM_SW);
    localparam int CW = $clog2(DEBOUNCE_LIMIT);
    logic [NUM_SW-1:0] sync, req;
    state_t            state, state_d;
    logic [IW-1:0]     rr_ptr, g, pick, idx, g_next;
    logic [CW-1:0]     cnt;
    logic              target, found, stable, done;
    sync_2ff #(.WIDTH(NUM_SW)) u_sync (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .d       (i_Switch),
        .q       (sync)
    );
    assign req    = sync ^ o_Switch;
    assign g_next = g == IW'(NUM_SW - 1) ? '0 : g + 1'b1;
    // round-robin search: the requester nearest to rr_ptr (in wrap order) wins
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_SW - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_SW);
            if (req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
    // FSM next state; a COUNT ends either on a bounce or when the limit is reached
    always_comb begin
        stable  = sync[g] == target;
        done    = state == COUNT && (!stable || cnt == CW'(DEBOUNCE_LIMIT - 1));
        state_d = state == IDLE ? (found ? COUNT : IDLE) : (done ? IDLE : COUNT);
    end
    // state register
    always_ff @(posedge i_Clk)
        if (i_Reset) state <= IDLE;
        else state <= state_d;
    // grant latch, shared counter, round-robin pointer and committed outputs
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            rr_ptr    <= '0;
            g         <= '0;
            target    <= 1'b0;
            cnt       <= '0;
            o_Switch  <= '0;
            o_Release <= '0;
            o_LED     <= '0;
        end else begin
            o_Release <= '0;
            if (state == IDLE && found) begin
                g      <= pick;
                target <= sync[pick];
                cnt    <= '0;
            end else if (done) begin
                rr_ptr <= g_next;
                if (stable) begin
                    o_Switch[g] <= target;
                    if (!target) begin
                        o_Release[g] <= 1'b1;
                        o_LED[g]     <= ~o_LED[g];
                    end
                end
            end else if (state == COUNT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: directed plus randomized checks against a timestamp-based reference model
module tb_debounce_scheduler;
    localparam int N   = 4;
    localparam int LIM = 4;
    logic         i_Clk = 1'b0;
    logic         i_Reset = 1'b1;
    logic [N-1:0] i_Switch = '0;
    logic [N-1:0] o_Switch, o_Release, o_LED;
    int n_cmp = 0;
    int n_fail = 0;
    debounce_scheduler #(.NUM_SW(N), .DEBOUNCE_LIMIT(LIM)) dut (
        .i_Clk     (i_Clk),
        .i_Reset   (i_Reset),
        .i_Switch  (i_Switch),
        .o_Switch  (o_Switch),
        .o_Release (o_Release),
        .o_LED     (o_LED)
    );
    always #5 i_Clk = ~i_Clk;
    // reference model: pins seen two edges late; a grant at edge t commits at edge t+LIM
    // if the synchronized pin matched the target on every edge in between
    int           cyc = 0;
    logic [N-1:0] h1 = '0, h2 = '0, m_sw = '0, m_rel = '0, m_led = '0;
    bit           busy = 0;
    int           mg = 0, gt_cyc = 0, rr = 0, mi = 0;
    logic         tgt = 1'b0;
    always @(posedge i_Clk) begin
        cyc = cyc + 1;
        m_rel = '0;
        if (i_Reset) begin
            h1 = '0; h2 = '0; m_sw = '0; m_led = '0; busy = 0; rr = 0;
        end else begin
            if (busy) begin
                if (h2[mg] !== tgt) begin
                    busy = 0;
                    rr = (mg + 1) % N;
                end else if (cyc - gt_cyc == LIM) begin
                    m_sw[mg] = tgt;
                    if (!tgt) begin
                        m_rel[mg] = 1'b1;
                        m_led[mg] = ~m_led[mg];
                    end
                    busy = 0;
                    rr = (mg + 1) % N;
                end
            end else begin
                for (int k = 0; k < N && !busy; k++) begin
                    mi = (rr + k) % N;
                    if (h2[mi] != m_sw[mi]) begin
                        busy = 1; mg = mi; tgt = h2[mi]; gt_cyc = cyc;
                    end
                end
            end
            h2 = h1;
            h1 = i_Switch;
        end
    end
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask
    // advance n falling edges, comparing every cycle against the model
    task automatic adv(input int n);
        repeat (n) begin
            @(negedge i_Clk);
            chk("model", {20'd0, o_Switch, o_Release, o_LED}, {20'd0, m_sw, m_rel, m_led});
            chk("release_onehot", 32'($countones(o_Release) <= 1), 32'd1);
        end
    endtask
    int hold[N];
    initial begin
        adv(3);
        i_Reset = 1'b0;
        adv(1);
        chk("reset_sw", {28'd0, o_Switch}, 32'd0);
        chk("reset_rel", {28'd0, o_Release}, 32'd0);
        chk("reset_led", {28'd0, o_LED}, 32'd0);
        // clean press then release on switch 0
        i_Switch[0] = 1'b1;
        adv(6);
        chk("press0_early", {31'd0, o_Switch[0]}, 32'd0);
        adv(1);
        chk("press0_commit", {31'd0, o_Switch[0]}, 32'd1);
        adv(13);
        i_Switch[0] = 1'b0;
        adv(6);
        chk("rel0_early", {28'd0, o_Switch, o_Release}, 32'h10);
        adv(1);
        chk("rel0_commit", {24'd0, o_Switch, o_Release}, 32'h01);
        chk("rel0_led", {28'd0, o_LED}, 32'h1);
        adv(1);
        chk("rel0_pulse_end", {28'd0, o_Release}, 32'h0);
        adv(12);
        // bouncing press on switch 2
        for (int p = 0; p < 4; p++) begin
            i_Switch[2] = (p % 2 == 0);
            adv(2);
        end
        chk("bounce2_nocommit", {31'd0, o_Switch[2]}, 32'd0);
        i_Switch[2] = 1'b1;
        adv(6);
        chk("bounce2_early", {31'd0, o_Switch[2]}, 32'd0);
        adv(1);
        chk("bounce2_commit", {31'd0, o_Switch[2]}, 32'd1);
        chk("bounce2_led", {28'd0, o_LED}, 32'h1);
        adv(10);
        // simultaneous release of switches 1 and 3 with rr_ptr = 2
        i_Reset = 1'b1;
        i_Switch = '0;
        adv(2);
        i_Reset = 1'b0;
        i_Switch[3] = 1'b1;
        adv(8);
        i_Switch[1] = 1'b1;
        adv(8);
        chk("pair_setup", {28'd0, o_Switch}, 32'ha);
        i_Switch[1] = 1'b0;
        i_Switch[3] = 1'b0;
        adv(6);
        chk("pair_early", {28'd0, o_Release}, 32'h0);
        adv(1);
        chk("pair_first", {24'd0, o_Release, o_Switch}, 32'h82);
        adv(4);
        chk("pair_gap", {28'd0, o_Release}, 32'h0);
        adv(1);
        chk("pair_second", {24'd0, o_Release, o_Switch}, 32'h20);
        chk("pair_led", {28'd0, o_LED}, 32'ha);
        adv(5);
        // switch 1 blips while switch 0 is counting
        i_Switch[0] = 1'b1;
        adv(1);
        i_Switch[1] = 1'b1;
        adv(2);
        i_Switch[1] = 1'b0;
        adv(10);
        chk("blip1_sw", {28'd0, o_Switch}, 32'h1);
        chk("blip1_led", {28'd0, o_LED}, 32'ha);
        // reset mid-COUNT on a release, with a press pending on switch 3
        i_Switch[0] = 1'b0;
        adv(3);
        i_Switch[3] = 1'b1;
        adv(1);
        i_Reset = 1'b1;
        adv(1);
        chk("rst_mid_out", {20'd0, o_Switch, o_Release, o_LED}, 32'h0);
        i_Reset = 1'b0;
        adv(6);
        chk("rst_redeb_early", {28'd0, o_Switch}, 32'h0);
        adv(1);
        chk("rst_redeb_commit", {24'd0, o_Switch, o_Release}, 32'h80);
        adv(5);
        // randomized bouncing pins with occasional resets
        for (int i = 0; i < N; i++) hold[i] = 1;
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    i_Switch[i] = ~i_Switch[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 5);
                end
            end
            i_Reset = ($urandom_range(0, 799) == 0);
            adv(1);
        end
        i_Reset = 1'b0;
        adv(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
